// File: rtl/regfile_multiport.sv
// Multi-port CPU register file for the PDP-11 core.
// Two combinational read ports and three write sources per cycle:
// port W (word or sign-extended byte), the autoinc/autodec update port,
// and the PC advance. When sources collide on one register, the
// higher-priority source wins outright: W, then UPD, then PC_INC.
module regfile_multiport #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int SELW     = 3,
  parameter int PC_IDX   = 7,
  parameter int SP_IDX   = 6,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0,
  parameter int BYPASS   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SELW-1:0]  sela,
  input  logic [SELW-1:0]  selb,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic [SELW-1:0]  selw,
  input  logic             byte_w,
  input  logic [WIDTH-1:0] w,
  input  logic             upd,
  input  logic [SELW-1:0]  selu,
  input  logic [2:0]       delta,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] pc,
  output logic             odd_pc
);

  // Elaboration-time sanity checks on the parameter set.
  if (WIDTH < 9) begin : g_bad_width
    $error("regfile_multiport: WIDTH must be at least 9");
  end
  if (NREGS < 8 || NREGS != (1 << SELW)) begin : g_bad_nregs
    $error("regfile_multiport: NREGS must be 2**SELW and at least 8");
  end
  if (PC_IDX >= NREGS || SP_IDX >= NREGS || SP_IDX == PC_IDX) begin : g_bad_idx
    $error("regfile_multiport: PC_IDX/SP_IDX out of range or equal");
  end

  logic [WIDTH-1:0] regs      [NREGS];
  logic [WIDTH-1:0] next_regs [NREGS];
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] delta_ext;
  logic [WIDTH-1:0] pc_step_ext;
  logic             pc_commit;

  // Port-W data: a byte write (MOVB to register) sign-extends the low byte.
  assign w_data      = byte_w ? {{(WIDTH-8){w[7]}}, w[7:0]} : w;
  assign delta_ext   = {{(WIDTH-3){delta[2]}}, delta};
  assign pc_step_ext = WIDTH'(PC_STEP);

  // PC counts as committed whenever any source targets it this cycle.
  assign pc_commit = (we  && selw == SELW'(PC_IDX)) ||
                     (upd && selu == SELW'(PC_IDX)) ||
                     pc_inc;

  // Per-register next value, resolving collisions by fixed priority.
  always_comb begin
    next_regs = regs;
    for (int i = 0; i < NREGS; i++) begin
      if (we && selw == SELW'(i)) begin
        next_regs[i] = w_data;
      end else if (upd && selu == SELW'(i)) begin
        next_regs[i] = regs[i] + delta_ext;
      end else if (pc_inc && i == PC_IDX) begin
        next_regs[i] = regs[i] + pc_step_ext;
      end
    end
  end

  // Register array write-back; PC comes out of reset at RESET_PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == PC_IDX) ? WIDTH'(RESET_PC) : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= next_regs[i];
      end
    end
  end

  // Sticky odd-PC flag for the bus unit's trap logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      odd_pc <= 1'b0;
    end else if (pc_commit && next_regs[PC_IDX][0]) begin
      odd_pc <= 1'b1;
    end
  end

  // Read ports; optional forwarding of port-W data only.
  always_comb begin
    a = regs[sela];
    b = regs[selb];
    if (BYPASS != 0 && we && selw == sela) a = w_data;
    if (BYPASS != 0 && we && selw == selb) b = w_data;
  end

  assign pc = regs[PC_IDX];

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed testbench for regfile_multiport: a default build and a BYPASS=1
// build share the same stimulus so their register contents stay identical.
module tb_regfile_multiport;

  logic        clk;
  logic        reset_n;
  logic [2:0]  sela, selb, selw, selu, delta;
  logic        we, byte_w, upd, pc_inc;
  logic [15:0] w;
  logic [15:0] a, b, pc, a_byp, b_byp, pc_byp;
  logic        odd_pc, odd_pc_byp;
  int          checks;
  int          errors;

  regfile_multiport dut (
    .clk(clk), .reset_n(reset_n), .sela(sela), .selb(selb), .a(a), .b(b),
    .we(we), .selw(selw), .byte_w(byte_w), .w(w), .upd(upd), .selu(selu),
    .delta(delta), .pc_inc(pc_inc), .pc(pc), .odd_pc(odd_pc)
  );

  regfile_multiport #(.BYPASS(1)) dut_byp (
    .clk(clk), .reset_n(reset_n), .sela(sela), .selb(selb), .a(a_byp), .b(b_byp),
    .we(we), .selw(selw), .byte_w(byte_w), .w(w), .upd(upd), .selu(selu),
    .delta(delta), .pc_inc(pc_inc), .pc(pc_byp), .odd_pc(odd_pc_byp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we = 1'b0; byte_w = 1'b0; upd = 1'b0; pc_inc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle();
    sela = 3'd0; selb = 3'd0; selw = 3'd0; selu = 3'd0; delta = 3'd0; w = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    checks++; if (pc !== 16'd0) begin errors++; $display("[TB] FAIL reset_pc got %o expected %o", pc, 16'd0); end
    checks++; if (odd_pc !== 1'b0) begin errors++; $display("[TB] FAIL reset_odd got %b expected 0", odd_pc); end
    we = 1'b1; selw = 3'd3; w = 16'o777; tick();
    selw = 3'd7; w = 16'o1001; tick(); idle();
    checks++; if (odd_pc !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_odd got %b expected 1", odd_pc); end
    // Mid-cycle async reset while a write is being requested.
    we = 1'b1; selw = 3'd3; w = 16'o55;
    #2 reset_n = 1'b0;
    #1 sela = 3'd3; selb = 3'd7;
    #1;
    checks++; if (a !== 16'd0) begin errors++; $display("[TB] FAIL async_reset_r3 got %o expected %o", a, 16'd0); end
    checks++; if (b !== 16'd0) begin errors++; $display("[TB] FAIL async_reset_r7 got %o expected %o", b, 16'd0); end
    checks++; if (pc !== 16'd0) begin errors++; $display("[TB] FAIL async_reset_pc got %o expected %o", pc, 16'd0); end
    checks++; if (odd_pc !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_odd got %b expected 0", odd_pc); end
    tick();
    checks++; if (a !== 16'd0) begin errors++; $display("[TB] FAIL reset_hold_write got %o expected %o", a, 16'd0); end
    idle(); reset_n = 1'b1;
  endtask

  task automatic test_write();
    we = 1'b1; selw = 3'd3; w = 16'o123456; tick(); idle();
    sela = 3'd3;
    checks++; if (a !== 16'o123456) begin errors++; $display("[TB] FAIL word_write got %o expected %o", a, 16'o123456); end
    we = 1'b1; byte_w = 1'b1; w = 16'h00F0; tick(); idle();
    checks++; if (a !== 16'hFFF0) begin errors++; $display("[TB] FAIL byte_write_neg got %h expected %h", a, 16'hFFF0); end
    we = 1'b1; byte_w = 1'b1; w = 16'h1234; tick(); idle();
    checks++; if (a !== 16'h0034) begin errors++; $display("[TB] FAIL byte_write_pos got %h expected %h", a, 16'h0034); end
  endtask

  task automatic test_update();
    we = 1'b1; selw = 3'd2; w = 16'd0; tick(); idle();
    sela = 3'd2;
    upd = 1'b1; selu = 3'd2; delta = 3'b110; tick(); idle();
    checks++; if (a !== 16'hFFFE) begin errors++; $display("[TB] FAIL autodec_wrap got %h expected %h", a, 16'hFFFE); end
    upd = 1'b1; delta = 3'b010; tick(); idle();
    checks++; if (a !== 16'h0000) begin errors++; $display("[TB] FAIL autoinc_to_zero got %h expected %h", a, 16'h0000); end
    upd = 1'b1; delta = 3'b010; tick(); idle();
    checks++; if (a !== 16'h0002) begin errors++; $display("[TB] FAIL autoinc_two got %h expected %h", a, 16'h0002); end
    upd = 1'b1; delta = 3'b111; tick(); idle();
    checks++; if (a !== 16'h0001) begin errors++; $display("[TB] FAIL delta_minus1 got %h expected %h", a, 16'h0001); end
    upd = 1'b1; delta = 3'b001; tick(); idle();
    checks++; if (a !== 16'h0002) begin errors++; $display("[TB] FAIL delta_plus1 got %h expected %h", a, 16'h0002); end
    we = 1'b1; selw = 3'd4; w = 16'hFFFF; tick(); idle();
    upd = 1'b1; selu = 3'd4; delta = 3'b010; tick(); idle();
    sela = 3'd4;
    checks++; if (a !== 16'h0001) begin errors++; $display("[TB] FAIL ones_plus2 got %h expected %h", a, 16'h0001); end
  endtask

  task automatic test_conflict();
    we = 1'b1; selw = 3'd5; w = 16'd100; upd = 1'b1; selu = 3'd5; delta = 3'b010;
    tick(); idle();
    sela = 3'd5;
    checks++; if (a !== 16'd100) begin errors++; $display("[TB] FAIL w_over_upd got %0d expected %0d", a, 100); end
    we = 1'b1; selw = 3'd7; w = 16'o1000; pc_inc = 1'b1; tick(); idle();
    checks++; if (pc !== 16'o1000) begin errors++; $display("[TB] FAIL w_over_pcinc got %o expected %o", pc, 16'o1000); end
    upd = 1'b1; selu = 3'd7; delta = 3'b110; pc_inc = 1'b1; tick(); idle();
    checks++; if (pc !== 16'o776) begin errors++; $display("[TB] FAIL upd_over_pcinc got %o expected %o", pc, 16'o776); end
  endtask

  task automatic test_parallel();
    we = 1'b1; selw = 3'd1; w = 16'hBEEF;
    upd = 1'b1; selu = 3'd6; delta = 3'b110;
    pc_inc = 1'b1;
    tick(); idle();
    sela = 3'd1; selb = 3'd6;
    checks++; if (a !== 16'hBEEF) begin errors++; $display("[TB] FAIL par_r1 got %h expected %h", a, 16'hBEEF); end
    checks++; if (b !== 16'hFFFE) begin errors++; $display("[TB] FAIL par_sp got %h expected %h", b, 16'hFFFE); end
    checks++; if (pc !== 16'o1000) begin errors++; $display("[TB] FAIL par_pc got %o expected %o", pc, 16'o1000); end
    checks++; if (odd_pc !== 1'b0) begin errors++; $display("[TB] FAIL even_pc_odd got %b expected 0", odd_pc); end
  endtask

  task automatic test_odd_pc();
    we = 1'b1; selw = 3'd7; w = 16'o1001; tick(); idle();
    checks++; if (odd_pc !== 1'b1) begin errors++; $display("[TB] FAIL odd_set got %b expected 1", odd_pc); end
    pc_inc = 1'b1; tick(); idle();
    checks++; if (pc !== 16'o1003) begin errors++; $display("[TB] FAIL pc_step_odd got %o expected %o", pc, 16'o1003); end
    we = 1'b1; selw = 3'd7; w = 16'o2000; tick(); idle();
    checks++; if (odd_pc !== 1'b1) begin errors++; $display("[TB] FAIL odd_sticky got %b expected 1", odd_pc); end
    checks++; if (pc !== 16'o2000) begin errors++; $display("[TB] FAIL pc_even_again got %o expected %o", pc, 16'o2000); end
  endtask

  task automatic test_bypass();
    sela = 3'd2; selb = 3'd2;
    we = 1'b1; selw = 3'd2; w = 16'h5A5A;
    #1;
    checks++; if (a_byp !== 16'h5A5A) begin errors++; $display("[TB] FAIL bypass_word got %h expected %h", a_byp, 16'h5A5A); end
    checks++; if (a !== 16'h0002) begin errors++; $display("[TB] FAIL no_bypass_word got %h expected %h", a, 16'h0002); end
    byte_w = 1'b1; w = 16'h0080;
    #1;
    checks++; if (b_byp !== 16'hFF80) begin errors++; $display("[TB] FAIL bypass_byte got %h expected %h", b_byp, 16'hFF80); end
    tick(); idle();
    checks++; if (a !== 16'hFF80) begin errors++; $display("[TB] FAIL bypass_commit got %h expected %h", a, 16'hFF80); end
    sela = 3'd3; upd = 1'b1; selu = 3'd3; delta = 3'b001;
    #1;
    checks++; if (a_byp !== 16'h0034) begin errors++; $display("[TB] FAIL upd_not_forwarded got %h expected %h", a_byp, 16'h0034); end
    tick(); idle();
    checks++; if (a_byp !== 16'h0035) begin errors++; $display("[TB] FAIL upd_commit got %h expected %h", a_byp, 16'h0035); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_update();
    test_conflict();
    test_parallel();
    test_odd_pc();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
